axis_master_fifo: RTL and testbench

- Next-generation AXI-Stream master output stage with a parametrised elastic FIFO between the pixel producer and the AXI-Stream slave.
- Adds full upstream backpressure (ready_out), which the single-register stage lacks.
- Adds an optional internal generator for tlast (end of line) and tuser (start of frame) from programmed line/frame geometry.
- Sits at the output of each image-processing block, driving the next block's AXI-Stream slave.

---
 rtl/axis_master_fifo.sv | 129 ++++++++++++
 tb/tb_axis_master_fifo.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_master_fifo.sv
// AXI-Stream master output stage: elastic FWFT FIFO with upstream backpressure
// and optional internal tlast/tuser generation from line/frame geometry.
module axis_master_fifo #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 8,
    parameter int MARKER_MODE = 0,
    parameter int LINE_LEN    = 640,
    parameter int FRAME_LINES = 480
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       valid_in,
    output logic                       ready_out,
    input  logic                       last_in,
    input  logic                       user_in,
    input  logic                       flush,
    output logic [DATA_WIDTH-1:0]      m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic                       m_axis_tuser,
    output logic [$clog2(DEPTH):0]     fill_level,
    output logic                       frame_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam int RW = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
    localparam int EW = DATA_WIDTH + 2;

    logic [EW-1:0]  mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           alive;
    logic [CW-1:0]  col;
    logic [RW-1:0]  row;
    logic [RW-1:0]  out_row;
    logic           frame_done_r;

    logic           empty;
    logic           wr_en;
    logic           rd_en;
    logic           col_end;
    logic           row_end;
    logic           out_row_end;
    logic           wr_last;
    logic           wr_user;
    logic [EW-1:0]  head;

    assign empty       = (count == '0);
    // ready depends only on registered state, never on m_axis_tready
    assign ready_out   = alive && (count != (AW+1)'(DEPTH));
    assign wr_en       = valid_in && ready_out && !flush;
    assign rd_en       = !empty && m_axis_tready && !flush;

    assign col_end     = (col == CW'(LINE_LEN - 1));
    assign row_end     = (row == RW'(FRAME_LINES - 1));
    assign out_row_end = (out_row == RW'(FRAME_LINES - 1));

    assign wr_last = (MARKER_MODE == 1) ? col_end : last_in;
    assign wr_user = (MARKER_MODE == 1) ? ((col == '0) && (row == '0)) : user_in;

    assign head          = mem[rd_ptr];
    assign m_axis_tvalid = !empty;
    assign m_axis_tdata  = empty ? '0 : head[DATA_WIDTH-1:0];
    assign m_axis_tlast  = !empty && head[DATA_WIDTH];
    assign m_axis_tuser  = !empty && head[DATA_WIDTH+1];
    assign fill_level    = count;
    assign frame_done    = frame_done_r;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {wr_user, wr_last, data_in};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive        <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            col          <= '0;
            row          <= '0;
            out_row      <= '0;
            frame_done_r <= 1'b0;
        end else begin
            alive <= 1'b1;
            if (flush) begin
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                count        <= '0;
                col          <= '0;
                row          <= '0;
                out_row      <= '0;
                frame_done_r <= 1'b0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (rd_en) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({wr_en, rd_en})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase

                // input-side geometry counters drive the generated markers
                if (wr_en) begin
                    col <= col_end ? '0 : col + 1'b1;
                    if (col_end) begin
                        row <= row_end ? '0 : row + 1'b1;
                    end
                end

                // output-side line counter locates the frame's final tlast
                if (rd_en && m_axis_tlast) begin
                    out_row <= out_row_end ? '0 : out_row + 1'b1;
                end
                frame_done_r <= (MARKER_MODE == 1) && rd_en && m_axis_tlast && out_row_end;
            end
        end
    end

endmodule

// File: tb/tb_axis_master_fifo.sv
// Scoreboard bench: one pass-through-marker instance and one generated-marker
// instance share stimulus; a negedge monitor compares both against queue models.
module tb_axis_master_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] data_in;
    logic        valid_in;
    logic        last_in;
    logic        user_in;
    logic        flush;
    logic        m_axis_tready;

    logic        ready0, tvalid0, tlast0, tuser0, fd0;
    logic [31:0] tdata0;
    logic [3:0]  fill0;
    logic        ready1, tvalid1, tlast1, tuser1, fd1;
    logic [31:0] tdata1;
    logic [3:0]  fill1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] d;
        logic        l;
        logic        u;
        logic        fe;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_in    = 0;
    bit   fd_pend = 1'b0;
    int   fd_cnt  = 0;
    bit   alive_m;
    bit   rand_rdy = 1'b0;

    always #5 clk = ~clk;

    axis_master_fifo #(
        .DATA_WIDTH(32), .DEPTH(8), .MARKER_MODE(0), .LINE_LEN(4), .FRAME_LINES(2)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready0), .last_in(last_in), .user_in(user_in), .flush(flush),
        .m_axis_tdata(tdata0), .m_axis_tvalid(tvalid0), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(tlast0), .m_axis_tuser(tuser0), .fill_level(fill0),
        .frame_done(fd0)
    );

    axis_master_fifo #(
        .DATA_WIDTH(32), .DEPTH(8), .MARKER_MODE(1), .LINE_LEN(4), .FRAME_LINES(2)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready1), .last_in(last_in), .user_in(user_in), .flush(flush),
        .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(tlast1), .m_axis_tuser(tuser1), .fill_level(fill1),
        .frame_done(fd1)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, exp, $time);
        end
    endtask

    // ready is 1 from the first clock edge after reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) alive_m <= 1'b0;
        else        alive_m <= 1'b1;
    end

    always @(posedge clk) begin
        #1;
        if (rand_rdy) m_axis_tready = ($urandom % 2 == 0);
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        int sz;
        bit rexp;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            n_in    = 0;
            fd_pend = 1'b0;
        end else begin
            sz   = q0.size();
            rexp = alive_m && (sz < 8);
            chk("fill0", fill0, sz);
            chk("fill1", fill1, q1.size());
            chk("tvalid0", tvalid0, sz != 0);
            chk("tvalid1", tvalid1, q1.size() != 0);
            chk("ready0", ready0, rexp);
            chk("ready1", ready1, rexp);
            if (sz != 0) begin
                chk("tdata0", tdata0, q0[0].d);
                chk("tlast0", tlast0, q0[0].l);
                chk("tuser0", tuser0, q0[0].u);
            end else begin
                chk("idle0", {tdata0, tlast0, tuser0}, 0);
            end
            if (q1.size() != 0) begin
                chk("tdata1", tdata1, q1[0].d);
                chk("tlast1", tlast1, q1[0].l);
                chk("tuser1", tuser1, q1[0].u);
            end else begin
                chk("idle1", {tdata1, tlast1, tuser1}, 0);
            end
            chk("frame_done1", fd1, fd_pend);
            chk("frame_done0", fd0, 0);
            if (fd1) fd_cnt++;

            if (flush) begin
                q0.delete();
                q1.delete();
                n_in    = 0;
                fd_pend = 1'b0;
            end else begin
                fd_pend = 1'b0;
                if (q1.size() != 0 && m_axis_tready) begin
                    fd_pend = q1[0].fe;
                    void'(q1.pop_front());
                end
                if (q0.size() != 0 && m_axis_tready) void'(q0.pop_front());
                if (valid_in && rexp) begin
                    q0.push_back('{d: data_in, l: last_in, u: user_in, fe: 1'b0});
                    q1.push_back('{d: data_in, l: (n_in % 4 == 3), u: (n_in == 0), fe: (n_in == 7)});
                    n_in = (n_in + 1) % 8;
                end
            end
        end
    end

    task automatic send(input logic [31:0] d, input logic l, input logic u);
        bit acc = 1'b0;
        valid_in = 1'b1;
        data_in  = d;
        last_in  = l;
        user_in  = u;
        for (int k = 0; k < 300 && !acc; k++) begin
            @(negedge clk);
            acc = ready0;
            @(posedge clk);
            #1;
        end
        valid_in = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 400 && (q0.size() != 0 || q1.size() != 0); k++) @(negedge clk);
        chk("drain0", q0.size(), 0);
        chk("drain1", q1.size(), 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int fd_start;
        rst_n = 1'b1; data_in = '0; valid_in = 1'b0; last_in = 1'b0;
        user_in = 1'b0; flush = 1'b0; m_axis_tready = 1'b0;
        #2 rst_n = 1'b0;
        #3;
        chk("rst_ready", ready0, 0);
        chk("rst_outs0", {tvalid0, tdata0, tlast0, tuser0, fill0, fd0}, 0);
        chk("rst_outs1", {tvalid1, tdata1, tlast1, tuser1, fill1, fd1}, 0);
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // back-to-back short burst
        m_axis_tready = 1'b1;
        send(32'h11, 1'b0, 1'b1);
        send(32'h22, 1'b0, 1'b0);
        send(32'h33, 1'b1, 1'b0);
        drain();

        // fill past capacity with sink stalled, then release
        m_axis_tready = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) send(32'h100 + i, i[0], i[1]);
            end
            begin
                idle(14);
                chk("full_level", fill0, 8);
                chk("full_ready", ready0, 0);
                m_axis_tready = 1'b1;
            end
        join
        drain();

        // randomized sink backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 200; i++) send($urandom, 1'($urandom % 2), 1'($urandom % 2));
        rand_rdy = 1'b0;
        idle(1);
        m_axis_tready = 1'b1;
        drain();

        // generated markers over two frames
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        fd_start = fd_cnt;
        for (int i = 0; i < 16; i++) send(32'h200 + i, 1'b0, 1'b0);
        drain();
        idle(3);
        chk("frame_done_count", fd_cnt - fd_start, 2);

        // flush with a beat presented on the flush cycle
        m_axis_tready = 1'b0;
        for (int i = 0; i < 5; i++) send(32'h300 + i, 1'b1, 1'b1);
        chk("pre_flush_level", fill0, 5);
        flush = 1'b1; valid_in = 1'b1; data_in = 32'hDEADBEEF;
        idle(1);
        flush = 1'b0; valid_in = 1'b0;
        @(negedge clk);
        chk("flush_level", fill0, 0);
        chk("flush_tvalid", tvalid0, 0);
        chk("flush_ready", ready0, 1);
        @(posedge clk); #1;
        m_axis_tready = 1'b1;
        send(32'h55, 1'b0, 1'b0);
        drain();

        // asynchronous reset mid-transfer
        m_axis_tready = 1'b0;
        for (int i = 0; i < 3; i++) send(32'h400 + i, 1'b1, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_outs0", {tvalid0, tdata0, tlast0, tuser0, fill0}, 0);
        chk("arst_outs1", {tvalid1, tdata1, tlast1, tuser1, fill1}, 0);
        chk("arst_ready", ready0, 0);
        idle(2);
        rst_n = 1'b1;
        idle(1);
        m_axis_tready = 1'b1;
        send(32'hA5A5A5A5, 1'b1, 1'b0);
        drain();
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
